// File: rtl/mcu_register_bridge_pkg.sv
// Shared types and constants for the MCU-to-register-file bridge.
// State encoding and byte-enable patterns live here so the FSM and its users agree.
package mcu_register_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_PULSE = 3'd1,
      ST_WR_HOLD  = 3'd2,
      ST_RD_PULSE = 3'd3,
      ST_RD_WAIT  = 3'd4,
      ST_RELEASE  = 3'd5
   } state_e;

   localparam logic [1:0] BE_LO   = 2'b01;
   localparam logic [1:0] BE_HI   = 2'b10;
   localparam logic [1:0] BE_WORD = 2'b11;

   // Odd byte addresses land in the upper lane of the 16-bit word.
   function automatic logic [1:0] write_be(input logic lane);
      return lane ? BE_HI : BE_LO;
   endfunction

endpackage

// File: rtl/mcu_register_bridge_if.sv
// Signal bundle between the MCU external bus, the bridge and the register file.
// The bridge uses the slave view; the MCU/register-file side uses the master view.
interface mcu_register_bridge_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);

   logic                  mcu_ncs;
   logic                  mcu_nrd;
   logic                  mcu_nwr;
   logic [ADDR_WIDTH:0]   mcu_addr;
   logic [7:0]            mcu_data_in;
   logic [7:0]            mcu_data_out;
   logic                  mcu_data_oe;

   logic                  reg_en;
   logic                  reg_rd;
   logic                  reg_wr;
   logic [1:0]            reg_be;
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [DATA_WIDTH-1:0] reg_data_in;
   logic [DATA_WIDTH-1:0] reg_data_out;

   modport slave (
      input  mcu_ncs, mcu_nrd, mcu_nwr, mcu_addr, mcu_data_in, reg_data_out,
      output mcu_data_out, mcu_data_oe,
      output reg_en, reg_rd, reg_wr, reg_be, reg_addr, reg_data_in
   );

   modport master (
      output mcu_ncs, mcu_nrd, mcu_nwr, mcu_addr, mcu_data_in, reg_data_out,
      input  mcu_data_out, mcu_data_oe,
      input  reg_en, reg_rd, reg_wr, reg_be, reg_addr, reg_data_in
   );

endinterface

// File: rtl/mcu_register_bridge_strobe_sync.sv
// Two-flop synchroniser plus two-sample low filter for one active-low MCU strobe.
// All flops reset high so a strobe never appears asserted out of reset.
module mcu_register_bridge_strobe_sync (
   input  logic clk,
   input  logic reset,
   input  logic strobe_n_i,
   output logic asserted_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= strobe_n_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   // A single low synchronised sample is treated as a glitch.
   assign asserted_o = ~sync_q & ~prev_q;

endmodule

// File: rtl/mcu_register_bridge.sv
// Converts asynchronous MCU byte-bus strobes into single-cycle word accesses on the
// register file, steering byte lanes and latching read data back for the MCU.
module mcu_register_bridge
   import mcu_register_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 16,
   parameter int READ_LATENCY = 2
) (
   input  logic               clk,
   input  logic               reset,
   mcu_register_bridge_if.slave bus
);

   localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LATENCY - 1);

   logic cs_act;
   logic nrd_act;
   logic nwr_act;
   logic rd_act;
   logic wr_act;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  lane_q, lane_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [1:0]            be_q, be_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [7:0]            dout_q, dout_d;

   mcu_register_bridge_strobe_sync u_sync_ncs (
      .clk        (clk),
      .reset      (reset),
      .strobe_n_i (bus.mcu_ncs),
      .asserted_o (cs_act)
   );

   mcu_register_bridge_strobe_sync u_sync_nrd (
      .clk        (clk),
      .reset      (reset),
      .strobe_n_i (bus.mcu_nrd),
      .asserted_o (nrd_act)
   );

   mcu_register_bridge_strobe_sync u_sync_nwr (
      .clk        (clk),
      .reset      (reset),
      .strobe_n_i (bus.mcu_nwr),
      .asserted_o (nwr_act)
   );

   assign rd_act = cs_act & nrd_act;
   assign wr_act = cs_act & nwr_act;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         lane_q  <= 1'b0;
         data_q  <= '0;
         be_q    <= '0;
         cnt_q   <= '0;
         dout_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lane_q  <= lane_d;
         data_q  <= data_d;
         be_q    <= be_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      lane_d  = lane_q;
      data_d  = data_q;
      be_d    = be_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;

      case (state_q)
         ST_IDLE: begin
            if (rd_act && wr_act) begin
               state_d = ST_RELEASE;
            end else if (wr_act) begin
               addr_d  = bus.mcu_addr[ADDR_WIDTH:1];
               lane_d  = bus.mcu_addr[0];
               data_d  = DATA_WIDTH'({bus.mcu_data_in, bus.mcu_data_in});
               be_d    = write_be(bus.mcu_addr[0]);
               state_d = ST_WR_PULSE;
            end else if (rd_act) begin
               addr_d  = bus.mcu_addr[ADDR_WIDTH:1];
               lane_d  = bus.mcu_addr[0];
               be_d    = BE_WORD;
               state_d = ST_RD_PULSE;
            end
         end
         ST_WR_PULSE: state_d = ST_WR_HOLD;
         ST_WR_HOLD:  state_d = ST_RELEASE;
         ST_RD_PULSE: begin
            cnt_d   = '0;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (cnt_q == RD_LAST) begin
               dout_d  = lane_q ? bus.reg_data_out[15:8] : bus.reg_data_out[7:0];
               state_d = ST_RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // Hold here until the MCU lets go so a long strobe yields one access.
         ST_RELEASE: begin
            if (!rd_act && !wr_act) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.reg_en = (state_q == ST_WR_PULSE) || (state_q == ST_WR_HOLD) ||
                       (state_q == ST_RD_PULSE) || (state_q == ST_RD_WAIT);
   assign bus.reg_wr = (state_q == ST_WR_PULSE);
   assign bus.reg_rd = (state_q == ST_RD_PULSE);
   assign bus.reg_be = bus.reg_en ? be_q : 2'b00;
   assign bus.reg_addr     = addr_q;
   assign bus.reg_data_in  = data_q;
   assign bus.mcu_data_out = dout_q;

   // Unsynchronised on purpose: the MCU pins must turn around within its bus cycle.
   assign bus.mcu_data_oe = ~bus.mcu_ncs & ~bus.mcu_nrd;

endmodule
